// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// interrupt cause codes, mstatus bit positions and the sequencer state type.
package trap_ctrl_pkg;

    localparam int unsigned MXLEN = 32;

    // CSR addresses, kept in step with the CSR file.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [4:0] IRQ_CODE_SOFT  = 5'd3;
    localparam logic [4:0] IRQ_CODE_TIMER = 5'd7;
    localparam logic [4:0] IRQ_CODE_EXT   = 5'd11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_MEPC   = 3'd1,
        S_W_MCAUSE = 3'd2,
        S_W_MTVAL  = 3'd3,
        S_W_MSTAT  = 3'd4,
        S_RET_STAT = 3'd5,
        S_REDIR    = 3'd6
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_irq_arbiter.sv
// Fixed-priority interrupt arbiter: external > software > timer, gated by
// the per-source enables in mie and the global MIE bit.
module irq_arbiter
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = MXLEN
) (
    input  logic            irq_ext_i,
    input  logic            irq_soft_i,
    input  logic            irq_timer_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic            mstatus_mie_i,
    output logic            irq_take_o,
    output logic [4:0]      irq_code_o
);

    logic ext_en;
    logic soft_en;
    logic timer_en;
    logic unused_mie;

    assign ext_en   = irq_ext_i   & mie_i[IRQ_CODE_EXT];
    assign soft_en  = irq_soft_i  & mie_i[IRQ_CODE_SOFT];
    assign timer_en = irq_timer_i & mie_i[IRQ_CODE_TIMER];

    assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    always_comb begin
        irq_take_o = mstatus_mie_i & (ext_en | soft_en | timer_en);
        irq_code_o = '0;
        if (ext_en) begin
            irq_code_o = IRQ_CODE_EXT;
        end else if (soft_en) begin
            irq_code_o = IRQ_CODE_SOFT;
        end else if (timer_en) begin
            irq_code_o = IRQ_CODE_TIMER;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures an exception, interrupt or mret,
// writes mepc/mcause/mtval/mstatus one per cycle, then redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = MXLEN
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            instr_retire,
    input  logic [XLEN-1:0] next_pc,
    input  logic            irq_ext,
    input  logic            irq_soft,
    input  logic            irq_timer,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mie_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            trap_wr_en,
    output logic [11:0]     trap_wr_addr,
    output logic [XLEN-1:0] trap_wr_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_busy
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] snap_q, snap_d;
    logic [4:0]      code_q, code_d;
    logic            irq_q, irq_d;
    logic            ret_q, ret_d;

    logic            wr_en_q, wr_en_d;
    logic [11:0]     wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            irq_take;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] mstat_trap;
    logic [XLEN-1:0] mstat_ret;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^{exc_pc[1:0], next_pc[1:0]};

    irq_arbiter #(
        .XLEN (XLEN)
    ) u_irq_arbiter (
        .irq_ext_i     (irq_ext),
        .irq_soft_i    (irq_soft),
        .irq_timer_i   (irq_timer),
        .mie_i         (mie_in),
        .mstatus_mie_i (mstatus_in[MSTATUS_MIE]),
        .irq_take_o    (irq_take),
        .irq_code_o    (irq_code)
    );

    // Acceptance and sequencing; payload is held until the next acceptance.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        snap_d  = snap_q;
        code_d  = code_q;
        irq_d   = irq_q;
        ret_d   = ret_q;
        unique case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    epc_d   = {exc_pc[XLEN-1:2], 2'b00};
                    cause_d = {{(XLEN-5){1'b0}}, exc_code};
                    tval_d  = exc_tval;
                    snap_d  = mstatus_in;
                    code_d  = exc_code;
                    irq_d   = 1'b0;
                    ret_d   = 1'b0;
                    state_d = S_W_MEPC;
                end else if (instr_retire && irq_take) begin
                    epc_d   = {next_pc[XLEN-1:2], 2'b00};
                    cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                    tval_d  = '0;
                    snap_d  = mstatus_in;
                    code_d  = irq_code;
                    irq_d   = 1'b1;
                    ret_d   = 1'b0;
                    state_d = S_W_MEPC;
                end else if (mret_valid) begin
                    snap_d  = mstatus_in;
                    irq_d   = 1'b0;
                    ret_d   = 1'b1;
                    state_d = S_RET_STAT;
                end
            end
            S_W_MEPC:   state_d = S_W_MCAUSE;
            S_W_MCAUSE: state_d = S_W_MTVAL;
            S_W_MTVAL:  state_d = S_W_MSTAT;
            S_W_MSTAT:  state_d = S_REDIR;
            S_RET_STAT: state_d = S_REDIR;
            S_REDIR:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mstat_trap                                = snap_d;
        mstat_trap[MSTATUS_MPIE]                  = snap_d[MSTATUS_MIE];
        mstat_trap[MSTATUS_MIE]                   = 1'b0;
        mstat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        mstat_ret                                 = snap_d;
        mstat_ret[MSTATUS_MIE]                    = snap_d[MSTATUS_MPIE];
        mstat_ret[MSTATUS_MPIE]                   = 1'b1;
        mstat_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;

        vec_base = {mtvec_in[XLEN-1:2], 2'b00};
        vec_off  = '0;
        if (irq_d && (mtvec_in[1:0] == 2'b01)) begin
            vec_off = {{(XLEN-7){1'b0}}, code_d, 2'b00};
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the cycle the sequencer is actually in.
    always_comb begin
        wr_en_d       = 1'b0;
        wr_addr_d     = '0;
        wr_data_d     = '0;
        redir_valid_d = 1'b0;
        redir_pc_d    = '0;
        unique case (state_d)
            S_W_MEPC: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MEPC;
                wr_data_d = epc_d;
            end
            S_W_MCAUSE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MCAUSE;
                wr_data_d = cause_d;
            end
            S_W_MTVAL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MTVAL;
                wr_data_d = tval_d;
            end
            S_W_MSTAT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MSTATUS;
                wr_data_d = mstat_trap;
            end
            S_RET_STAT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MSTATUS;
                wr_data_d = mstat_ret;
            end
            S_REDIR: begin
                redir_valid_d = 1'b1;
                redir_pc_d    = ret_d ? mepc_in : (vec_base + vec_off);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            epc_q         <= '0;
            cause_q       <= '0;
            tval_q        <= '0;
            snap_q        <= '0;
            code_q        <= '0;
            irq_q         <= 1'b0;
            ret_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            snap_q        <= snap_d;
            code_q        <= code_d;
            irq_q         <= irq_d;
            ret_q         <= ret_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign trap_wr_en     = wr_en_q;
    assign trap_wr_addr   = wr_addr_q;
    assign trap_wr_data   = wr_data_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;
    assign trap_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, vectored interrupt, priority,
// mret, request collisions and mid-sequence reset.
module tb_trap_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic        instr_retire;
    logic [31:0] next_pc;
    logic        irq_ext;
    logic        irq_soft;
    logic        irq_timer;
    logic [31:0] mstatus_in;
    logic [31:0] mie_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        trap_wr_en;
    logic [11:0] trap_wr_addr;
    logic [31:0] trap_wr_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_busy;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    trap_ctrl #(.XLEN(32)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .instr_retire   (instr_retire),
        .next_pc        (next_pc),
        .irq_ext        (irq_ext),
        .irq_soft       (irq_soft),
        .irq_timer      (irq_timer),
        .mstatus_in     (mstatus_in),
        .mie_in         (mie_in),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .trap_wr_en     (trap_wr_en),
        .trap_wr_addr   (trap_wr_addr),
        .trap_wr_data   (trap_wr_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_busy      (trap_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".wr_en"}, {31'b0, trap_wr_en}, 32'h0);
        chk({tag, ".wr_addr"}, {20'b0, trap_wr_addr}, 32'h0);
        chk({tag, ".wr_data"}, trap_wr_data, 32'h0);
        chk({tag, ".rv"}, {31'b0, redirect_valid}, 32'h0);
        chk({tag, ".rpc"}, redirect_pc, 32'h0);
        chk({tag, ".busy"}, {31'b0, trap_busy}, 32'h0);
    endtask

    task automatic check_wr(input string tag, input logic [11:0] addr, input logic [31:0] data);
        chk({tag, ".wr_en"}, {31'b0, trap_wr_en}, 32'h1);
        chk({tag, ".wr_addr"}, {20'b0, trap_wr_addr}, {20'b0, addr});
        chk({tag, ".wr_data"}, trap_wr_data, data);
        chk({tag, ".rv"}, {31'b0, redirect_valid}, 32'h0);
        chk({tag, ".busy"}, {31'b0, trap_busy}, 32'h1);
    endtask

    task automatic check_redir(input string tag, input logic [31:0] pc);
        chk({tag, ".wr_en"}, {31'b0, trap_wr_en}, 32'h0);
        chk({tag, ".rv"}, {31'b0, redirect_valid}, 32'h1);
        chk({tag, ".rpc"}, redirect_pc, pc);
        chk({tag, ".busy"}, {31'b0, trap_busy}, 32'h1);
    endtask

    // Entered at T+1; optionally raises a second exc_valid during T+2.
    task automatic expect_trap(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                               input logic [31:0] tval, input logic [31:0] mstat,
                               input logic [31:0] rpc, input bit poke);
        check_wr({tag, ".mepc"}, 12'h341, epc);
        step();
        check_wr({tag, ".mcause"}, 12'h342, cause);
        if (poke) begin
            exc_valid = 1'b1;
            exc_code  = 5'd13;
            exc_pc    = 32'hBAD0;
            exc_tval  = 32'hBAD1;
        end
        step();
        exc_valid = 1'b0;
        check_wr({tag, ".mtval"}, 12'h343, tval);
        step();
        check_wr({tag, ".mstat"}, 12'h300, mstat);
        step();
        check_redir({tag, ".redir"}, rpc);
        step();
        check_idle({tag, ".done"});
    endtask

    initial begin
        reset        = 1'b0;
        exc_valid    = 1'b0;
        exc_code     = '0;
        exc_pc       = '0;
        exc_tval     = '0;
        mret_valid   = 1'b0;
        instr_retire = 1'b0;
        next_pc      = '0;
        irq_ext      = 1'b0;
        irq_soft     = 1'b0;
        irq_timer    = 1'b0;
        mstatus_in   = '0;
        mie_in       = '0;
        mtvec_in     = '0;
        mepc_in      = '0;

        step();
        step();
        check_idle("reset");
        reset = 1'b1;
        step();
        check_idle("post_reset");

        // Exception, direct mode
        exc_valid  = 1'b1;
        exc_code   = 5'd2;
        exc_pc     = 32'h100;
        exc_tval   = 32'hDEAD;
        mtvec_in   = 32'h200;
        mstatus_in = 32'h8;
        step();
        exc_valid = 1'b0;
        expect_trap("exc", 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h200, 1'b0);

        // Timer interrupt, vectored mode
        irq_timer    = 1'b1;
        mie_in       = 32'h80;
        instr_retire = 1'b1;
        next_pc      = 32'h44;
        mtvec_in     = 32'h201;
        step();
        instr_retire = 1'b0;
        expect_trap("tmr", 32'h44, 32'h80000007, 32'h0, 32'h1880, 32'h21C, 1'b0);
        step();
        check_idle("tmr_noretire");
        irq_timer = 1'b0;

        // External beats timer
        irq_ext      = 1'b1;
        irq_timer    = 1'b1;
        mie_in       = 32'h880;
        instr_retire = 1'b1;
        next_pc      = 32'h80;
        step();
        instr_retire = 1'b0;
        expect_trap("ext", 32'h80, 32'h8000000B, 32'h0, 32'h1880, 32'h22C, 1'b0);

        // Global MIE clear: nothing taken
        mstatus_in   = 32'h0;
        instr_retire = 1'b1;
        step();
        check_idle("mie0_a");
        step();
        check_idle("mie0_b");
        instr_retire = 1'b0;
        irq_ext      = 1'b0;
        irq_timer    = 1'b0;

        // mret
        mret_valid = 1'b1;
        mstatus_in = 32'h1880;
        mepc_in    = 32'h104;
        step();
        mret_valid = 1'b0;
        check_wr("mret.stat", 12'h300, 32'h1888);
        step();
        check_redir("mret.redir", 32'h104);
        step();
        check_idle("mret.done");

        // Exception and mret together; second exception at T+2 ignored
        exc_valid  = 1'b1;
        mret_valid = 1'b1;
        exc_code   = 5'd5;
        exc_pc     = 32'h203;
        exc_tval   = 32'h55;
        mtvec_in   = 32'h301;
        mstatus_in = 32'h0;
        mepc_in    = 32'h999;
        step();
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        expect_trap("collide", 32'h200, 32'h5, 32'h55, 32'h1800, 32'h300, 1'b1);
        step();
        check_idle("collide_after");

        // Reset during T+3 of a trap
        exc_valid  = 1'b1;
        exc_code   = 5'd4;
        exc_pc     = 32'h400;
        exc_tval   = 32'h1;
        mtvec_in   = 32'h200;
        mstatus_in = 32'h8;
        step();
        exc_valid = 1'b0;
        check_wr("rst.mepc", 12'h341, 32'h400);
        step();
        step();
        check_wr("rst.mtval", 12'h343, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_idle("rst.async");
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("rst.noredir");
        end

        exc_valid = 1'b1;
        exc_code  = 5'd2;
        exc_pc    = 32'h100;
        exc_tval  = 32'hDEAD;
        step();
        exc_valid = 1'b0;
        expect_trap("rst.again", 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h200, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
